// File: rtl/binary_search_16b_pkg.sv
// rtl/binary_search_16b_pkg.sv - shared types and defaults for the binary search initiator
package binary_search_16b_pkg;

    localparam int BS_WIDTH_DEF = 16;
    localparam int BS_STEPW_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_FINISH = 2'd2
    } bs_state_e;

endpackage

// File: rtl/binary_search_16b_midpoint.sv
// rtl/binary_search_16b_midpoint.sv - midpoint of the live search range
module bsearch_midpoint #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   lo_i,
    input  logic [WIDTH:0]   hi_i,
    output logic [WIDTH-1:0] mid_o
);

    logic [WIDTH:0] span;

    // lo + (hi-lo)/2 never overflows; the result fits WIDTH bits whenever lo <= hi.
    always_comb begin
        span  = hi_i - lo_i;
        mid_o = WIDTH'(lo_i + (span >> 1));
    end

endmodule

// File: rtl/comparator_16b.sv
// rtl/comparator_16b.sv - magnitude comparator producing one-hot great/equal/less flags
module comparator_16b #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             great,
    output logic             equal,
    output logic             less
);

    // Flags describe A relative to B.
    always_comb begin
        great = (a > b);
        equal = (a == b);
        less  = (a < b);
    end

endmodule

// File: rtl/binary_search_16b.sv
// rtl/binary_search_16b.sv - binary search driving a comparator B operand to find its A operand
module binary_search_16b
    import binary_search_16b_pkg::*;
#(
    parameter int WIDTH = BS_WIDTH_DEF,
    parameter int STEPW = BS_STEPW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_great,
    input  logic             cmp_equal,
    input  logic             cmp_less,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [STEPW-1:0] steps
);

    localparam logic [WIDTH:0] RANGE_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] ONE_X     = {{WIDTH{1'b0}}, 1'b1};

    bs_state_e        state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d, result_q, result_d;
    logic             found_q, found_d, err_q, err_d;
    logic [STEPW-1:0] steps_q, steps_d;

    logic [WIDTH:0]   guess_x, cand_lo, cand_hi;
    logic [WIDTH-1:0] mid;
    logic             great_only, less_only, underflow, exhausted;

    // Candidate range: full span when launching, else narrowed by the current flag.
    always_comb begin
        guess_x    = {1'b0, guess_q};
        great_only = ({cmp_great, cmp_equal, cmp_less} == 3'b100);
        less_only  = ({cmp_great, cmp_equal, cmp_less} == 3'b001);
        cand_lo    = lo_q;
        cand_hi    = hi_q;
        underflow  = 1'b0;
        if (state_q == ST_IDLE) begin
            cand_lo = '0;
            cand_hi = RANGE_MAX;
        end else begin
            if (great_only) begin
                cand_lo = guess_x + ONE_X;
            end
            if (less_only) begin
                cand_hi   = guess_x - ONE_X;
                underflow = (guess_q == '0);
            end
        end
        // A borrow out of guess-1 means the range is empty even though it compares large.
        exhausted = underflow || (cand_lo > cand_hi);
    end

    bsearch_midpoint #(.WIDTH(WIDTH)) u_midpoint (
        .lo_i  (cand_lo),
        .hi_i  (cand_hi),
        .mid_o (mid)
    );

    // Next-state logic: launch, probe one comparator answer per cycle, then a single done cycle.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
        steps_d  = steps_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lo_d    = cand_lo;
                    hi_d    = cand_hi;
                    guess_d = mid;
                    steps_d = '0;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_PROBE;
                end
            end
            ST_PROBE: begin
                steps_d = steps_q + {{(STEPW-1){1'b0}}, 1'b1};
                if ({cmp_great, cmp_equal, cmp_less} == 3'b010) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    state_d  = ST_FINISH;
                end else if (great_only || less_only) begin
                    lo_d = cand_lo;
                    hi_d = cand_hi;
                    if (exhausted) begin
                        found_d  = 1'b0;
                        result_d = guess_q;
                        state_d  = ST_FINISH;
                    end else begin
                        guess_d = mid;
                    end
                end else begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = guess_q;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any search without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
            steps_q  <= steps_d;
        end
    end

    assign guess  = guess_q;
    assign result = result_q;
    assign found  = found_q;
    assign err    = err_q;
    assign steps  = steps_q;
    assign busy   = (state_q == ST_PROBE);
    assign done   = (state_q == ST_FINISH);

endmodule

// File: tb/tb_binary_search_16b.sv
// tb/tb_binary_search_16b.sv - directed self-checking bench for binary_search_16b
module tb_binary_search_16b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] target = 16'd0;
    logic        use_stub = 1'b0;
    logic [2:0]  stub_flags = 3'b000;
    logic        c_great, c_equal, c_less;
    logic        great, equal, less;
    logic [15:0] guess, result;
    logic        busy, done, found, err;
    logic [4:0]  steps;

    int checks = 0;
    int failures = 0;
    int ref_q[$];
    int obs_q[$];
    int ndone;
    int cyc;
    int exp_s1, exp_s2;

    always #5 clk = ~clk;

    comparator_16b u_cmp (
        .a     (target),
        .b     (guess),
        .great (c_great),
        .equal (c_equal),
        .less  (c_less)
    );

    assign great = use_stub ? stub_flags[2] : c_great;
    assign equal = use_stub ? stub_flags[1] : c_equal;
    assign less  = use_stub ? stub_flags[0] : c_less;

    binary_search_16b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmp_great (great),
        .cmp_equal (equal),
        .cmp_less  (less),
        .guess     (guess),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .err       (err),
        .result    (result),
        .steps     (steps)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic build_ref(input int tgt);
        int lo, hi, g;
        ref_q.delete();
        lo = 0;
        hi = 65535;
        while (lo <= hi) begin
            g = lo + (hi - lo) / 2;
            ref_q.push_back(g);
            if (g == tgt) break;
            if (tgt > g) lo = g + 1;
            else hi = g - 1;
        end
    endtask

    task automatic compare_seq(input string tag);
        int mism;
        mism = (obs_q.size() != ref_q.size()) ? 1 : 0;
        for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++)
            if (obs_q[i] != ref_q[i]) mism++;
        check(tag, mism, 0);
    endtask

    task automatic run_search(input logic [15:0] tgt, input string tag);
        build_ref(int'(tgt));
        obs_q.delete();
        target = tgt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            if (busy) obs_q.push_back(int'(guess));
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_found"}, int'(found), 1);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_result"}, int'(result), int'(tgt));
        check({tag, "_steps"}, int'(steps), ref_q.size());
        compare_seq({tag, "_seq"});
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_result_hold"}, int'(result), int'(tgt));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_guess", int'(guess), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_found", int'(found), 0);
        check("rst_err", int'(err), 0);
        check("rst_result", int'(result), 0);
        check("rst_steps", int'(steps), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_search(16'd32767, "mid");
        check("mid_one_probe", int'(steps), 1);

        run_search(16'd0, "zero");
        check("zero_steps16", int'(steps), 16);
        check("zero_second_guess", obs_q.size() > 1 ? obs_q[1] : -1, 16383);

        run_search(16'd65535, "max");
        check("max_steps17", int'(steps), 17);
        check("max_second_guess", obs_q.size() > 1 ? obs_q[1] : -1, 49151);
        check("max_16th_guess", obs_q.size() > 15 ? obs_q[15] : -1, 65534);

        // Back-to-back searches with start held high.
        build_ref(60000);
        exp_s1 = ref_q.size();
        build_ref(4001);
        exp_s2 = ref_q.size();
        target = 16'd60000;
        start = 1'b1;
        ndone = 0;
        cyc = 0;
        while (ndone < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check("b2b1_found", int'(found), 1);
                    check("b2b1_result", int'(result), 60000);
                    check("b2b1_steps", int'(steps), exp_s1);
                    target = 16'd4001;
                end else begin
                    check("b2b2_found", int'(found), 1);
                    check("b2b2_result", int'(result), 4001);
                    check("b2b2_steps", int'(steps), exp_s2);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_both_done", ndone, 2);
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("b2b_done_count", ndone, 2);
        check("b2b_idle", int'(busy), 0);

        // Non-one-hot comparator flags.
        use_stub = 1'b1;
        stub_flags = 3'b101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("stub_done", int'(done), 1);
        check("stub_err", int'(err), 1);
        check("stub_found", int'(found), 0);
        check("stub_result", int'(result), 32767);
        check("stub_steps", int'(steps), 1);
        @(negedge clk);
        use_stub = 1'b0;
        stub_flags = 3'b000;

        // Reset during the fifth probe.
        target = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(busy && steps == 5'd4) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("rst5_reached", int'(busy && steps == 5'd4), 1);
        rst_n = 1'b0;
        #1;
        check("rst5_guess", int'(guess), 0);
        check("rst5_busy", int'(busy), 0);
        check("rst5_done", int'(done), 0);
        check("rst5_found", int'(found), 0);
        check("rst5_err", int'(err), 0);
        check("rst5_result", int'(result), 0);
        check("rst5_steps", int'(steps), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rst5_no_done", ndone, 0);

        // Start pulses while busy must not disturb the probe sequence.
        build_ref(12345);
        obs_q.delete();
        target = 16'd12345;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            if (busy) obs_q.push_back(int'(guess));
            @(negedge clk);
            cyc++;
            start = cyc[0];
        end
        start = 1'b0;
        check("busy_start_done", int'(done), 1);
        check("busy_start_found", int'(found), 1);
        check("busy_start_result", int'(result), 12345);
        check("busy_start_steps", int'(steps), ref_q.size());
        compare_seq("busy_start_seq");
        repeat (3) @(negedge clk);
        check("busy_start_idle", int'(busy), 0);

        run_search(16'd1, "after_all");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
